// File: rtl/capture_sprite_pkg.sv
// capture_sprite_pkg
// Shared constants and the controller state type for the tile capture block
// and the sprite addressing helper that the draw path also uses.
package capture_sprite_pkg;

    // Frame geometry
    localparam int FRAME_W  = 320;
    localparam int FRAME_H  = 240;
    localparam int DIM      = 8;

    // Bus widths
    localparam int FRAME_AW = 17;
    localparam int IMG_AW   = 14;
    localparam int PIX_W    = 24;
    localparam int SLOT_W   = IMG_AW - 6;
    localparam int IDX_W    = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/capture_sprite_if.sv
// capture_sprite_if
// Request, frame-buffer read and image-memory write signals of the capture
// block. The nonzero flag only exists when CAPTURE_NONZERO_EN is defined.
interface capture_sprite_if;
    import capture_sprite_pkg::*;

    logic                start;
    logic [FRAME_AW-1:0] data_in;
    logic [SLOT_W-1:0]   addr_in;
    logic                rdy;
    logic                done;
    logic [FRAME_AW-1:0] frame_addr;
    logic [PIX_W-1:0]    frame_data;
    logic [IMG_AW-1:0]   img_mem_addr;
    logic [PIX_W-1:0]    img_pixel_data;
    logic                img_we;
`ifdef CAPTURE_NONZERO_EN
    logic                nonzero;
`endif

`ifdef CAPTURE_NONZERO_EN
    modport slave (
        input  start, data_in, addr_in, frame_data,
        output rdy, done, frame_addr, img_mem_addr, img_pixel_data, img_we, nonzero
    );
    modport master (
        output start, data_in, addr_in, frame_data,
        input  rdy, done, frame_addr, img_mem_addr, img_pixel_data, img_we, nonzero
    );
`else
    modport slave (
        input  start, data_in, addr_in, frame_data,
        output rdy, done, frame_addr, img_mem_addr, img_pixel_data, img_we
    );
    modport master (
        output start, data_in, addr_in, frame_data,
        input  rdy, done, frame_addr, img_mem_addr, img_pixel_data, img_we
    );
`endif

endinterface

// File: rtl/capture_sprite_addr_gen.sv
// sprite_addr_gen
// Maps a tile base address and a row-major pixel index to a frame address.
// Shared with the draw path so capture and draw walk the tile identically.
// idx[2:0] is the column, idx[5:3] the row; arithmetic wraps at 17 bits.
module sprite_addr_gen
    import capture_sprite_pkg::*;
#(
    parameter int FRAME_W = capture_sprite_pkg::FRAME_W
)(
    input  logic [FRAME_AW-1:0] base,
    input  logic [IDX_W-1:0]    idx,
    output logic [FRAME_AW-1:0] frame_addr
);

    logic [FRAME_AW-1:0] col;
    logic [FRAME_AW-1:0] row;
    logic [FRAME_AW-1:0] row_off;

    // base + column + pitch * row, truncated to the frame address width
    always_comb begin
        col        = FRAME_AW'(idx[2:0]);
        row        = FRAME_AW'(idx[5:3]);
        row_off    = row * FRAME_AW'(FRAME_W);
        frame_addr = base + col + row_off;
    end

endmodule

// File: rtl/capture_sprite.sv
// capture_sprite
// Copies one DIM x DIM tile from the frame buffer into a 64-entry slot of
// sprite image memory. Reads are issued one per cycle; each write follows
// its read by one cycle because the frame RAM has a registered output.
// Optional feature macro: CAPTURE_NONZERO_EN adds the sticky nonzero flag.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | rdy=1, waiting for start; latches base/slot on accept
// READ  | one frame read per cycle, idx 0..63; writes trail by one
// DRAIN | last write (idx 63) in flight, done pulses, back to IDLE
module capture_sprite
    import capture_sprite_pkg::*;
#(
    parameter int FRAME_W = capture_sprite_pkg::FRAME_W,
    parameter int DIM     = capture_sprite_pkg::DIM
)(
    input  logic             clk,
    input  logic             rst_n,
    capture_sprite_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM * DIM - 1);

    state_t              state;
    state_t              state_nxt;
    logic [FRAME_AW-1:0] base;
    logic [SLOT_W-1:0]   slot;
    logic [IDX_W-1:0]    idx;
    logic                wr_vld;
    logic [IMG_AW-1:0]   wr_addr;
    logic [FRAME_AW-1:0] rd_addr;
    logic                accept;

    assign accept = (state == IDLE) && bus.start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = READ;
            READ:    if (idx == LAST_IDX) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and read index; start is ignored outside IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
            slot <= '0;
            idx  <= '0;
        end else if (accept) begin
            base <= bus.data_in;
            slot <= bus.addr_in;
            idx  <= '0;
        end else if (state == READ) begin
            idx  <= idx + IDX_W'(1);
        end
    end

    // Write stage: valid and destination trail the read by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld  <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_vld <= (state == READ);
            if (state == READ) begin
                wr_addr <= {slot, idx};
            end
        end
    end

    sprite_addr_gen #(
        .FRAME_W    (FRAME_W)
    ) u_addr_gen (
        .base       (base),
        .idx        (idx),
        .frame_addr (rd_addr)
    );

    assign bus.frame_addr   = rd_addr;
    assign bus.rdy          = (state == IDLE);
    assign bus.done         = (state == DRAIN);
    assign bus.img_we       = wr_vld;
    assign bus.img_mem_addr = wr_addr;
    // The frame RAM output register is the data stage of the write pipe,
    // so the pixel is forwarded straight through while a write is valid.
    assign bus.img_pixel_data = wr_vld ? bus.frame_data : '0;

`ifdef CAPTURE_NONZERO_EN
    logic nz_q;
    logic pix_nz;

    assign pix_nz = wr_vld && (bus.frame_data != '0);

    // Sticky flag, cleared on accept; the current write is ORed in below so
    // the flag already covers pixel 63 during the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nz_q <= 1'b0;
        end else if (accept) begin
            nz_q <= 1'b0;
        end else if (pix_nz) begin
            nz_q <= 1'b1;
        end
    end

    assign bus.nonzero = nz_q | pix_nz;
`endif

endmodule
